// File: rtl/versa_pkg.sv
// rtl/versa_pkg.sv - shared types and constants for the VERSA metadata loader
package versa_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WR_MIN,
      ST_WR_MAX,
      ST_RD_MIN,
      ST_RD_MAX,
      ST_DONE
   } state_t;

   // Word offsets of ER_min / ER_max from the block's word base
   localparam logic [13:0] ERMIN_OFS   = 14'd0;
   localparam logic [13:0] ERMAX_OFS   = 14'd1;
   localparam logic [1:0]  PER_WE_WORD = 2'b11;

endpackage

// File: rtl/versa_meta_loader_if.sv
// rtl/versa_meta_loader_if.sv - requester and peripheral-bus signals of the metadata loader
interface versa_meta_loader_if;

   logic        start;
   logic [15:0] load_min;
   logic [15:0] load_max;
   logic        bus_req;
   logic        bus_gnt;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_we;
   logic [15:0] per_dout;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] rd_min;
   logic [15:0] rd_max;

   modport master (
      input  start, load_min, load_max, bus_gnt, per_dout,
      output bus_req, per_addr, per_din, per_en, per_we,
             busy, done, err, rd_min, rd_max
   );

   modport slave (
      output start, load_min, load_max, bus_gnt, per_dout,
      input  bus_req, per_addr, per_din, per_en, per_we,
             busy, done, err, rd_min, rd_max
   );

endinterface

// File: rtl/versa_gnt_timer.sv
// rtl/versa_gnt_timer.sv - 8-bit grant-wait counter; expires on the LIMIT-th counted cycle
module versa_gnt_timer #(
   parameter logic [7:0] LIMIT = 8'd255
) (
   input  logic mclk,
   input  logic puc_rst,
   input  logic i_clr,
   input  logic i_cnt,
   output logic o_expire
);

   logic [7:0] r_cnt;

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst)
         r_cnt <= 8'd0;
      else if (i_clr)
         r_cnt <= 8'd0;
      else if (i_cnt)
         r_cnt <= r_cnt + 8'd1;
   end

   // Asserted while the last permitted cycle is being counted
   assign o_expire = i_cnt && (r_cnt == LIMIT - 8'd1);

endmodule

// File: rtl/versa_meta_loader.sv
// rtl/versa_meta_loader.sv - programs ER_min/ER_max; readback verify under VERSA_LOADER_VERIFY_EN
module versa_meta_loader
   import versa_pkg::*;
#(
   parameter logic [14:0] BASE_ADDR   = 15'h0140,
   parameter logic [7:0]  GNT_TIMEOUT = 8'd255
) (
   input  logic                mclk,
   input  logic                puc_rst,
   versa_meta_loader_if.master bus
);

   localparam logic [13:0] W_BASE = BASE_ADDR[14:1];

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_min;
   logic [15:0] r_max;
   logic        r_err;
   logic        w_expire;
   logic        w_bus_req;
   logic        w_per_en;
   logic [1:0]  w_per_we;
   logic [13:0] w_per_addr;
   logic [15:0] w_per_din;

   versa_gnt_timer #(.LIMIT(GNT_TIMEOUT)) u_gnt_timer (
      .mclk     (mclk),
      .puc_rst  (puc_rst),
      .i_clr    (r_state != ST_REQ),
      .i_cnt    ((r_state == ST_REQ) && !bus.bus_gnt),
      .o_expire (w_expire)
   );

   always_comb begin
      w_next     = r_state;
      w_bus_req  = 1'b0;
      w_per_en   = 1'b0;
      w_per_we   = 2'b00;
      w_per_addr = 14'd0;
      w_per_din  = 16'd0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start)
               w_next = (bus.load_min > bus.load_max) ? ST_DONE : ST_REQ;
         end
         ST_REQ: begin
            w_bus_req = 1'b1;
            if (bus.bus_gnt)
               w_next = ST_WR_MIN;
            else if (w_expire)
               w_next = ST_DONE;
         end
         ST_WR_MIN: begin
            w_bus_req = 1'b1;
            if (bus.bus_gnt) begin
               w_per_en   = 1'b1;
               w_per_we   = PER_WE_WORD;
               w_per_addr = W_BASE + ERMIN_OFS;
               w_per_din  = r_min;
               w_next     = ST_WR_MAX;
            end
         end
         ST_WR_MAX: begin
            w_bus_req = 1'b1;
            if (bus.bus_gnt) begin
               w_per_en   = 1'b1;
               w_per_we   = PER_WE_WORD;
               w_per_addr = W_BASE + ERMAX_OFS;
               w_per_din  = r_max;
`ifdef VERSA_LOADER_VERIFY_EN
               w_next     = ST_RD_MIN;
`else
               w_next     = ST_DONE;
`endif
            end
         end
`ifdef VERSA_LOADER_VERIFY_EN
         ST_RD_MIN: begin
            w_bus_req = 1'b1;
            if (bus.bus_gnt) begin
               w_per_en   = 1'b1;
               w_per_addr = W_BASE + ERMIN_OFS;
               w_next     = ST_RD_MAX;
            end
         end
         ST_RD_MAX: begin
            w_bus_req = 1'b1;
            if (bus.bus_gnt) begin
               w_per_en   = 1'b1;
               w_per_addr = W_BASE + ERMAX_OFS;
               w_next     = ST_DONE;
            end
         end
`endif
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

`ifdef VERSA_LOADER_VERIFY_EN
   logic [15:0] r_rd_min;
   logic [15:0] r_rd_max;
`endif

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         r_state  <= ST_IDLE;
         r_min    <= 16'd0;
         r_max    <= 16'd0;
         r_err    <= 1'b0;
`ifdef VERSA_LOADER_VERIFY_EN
         r_rd_min <= 16'd0;
         r_rd_max <= 16'd0;
`endif
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_min <= bus.load_min;
                  r_max <= bus.load_max;
                  r_err <= (bus.load_min > bus.load_max);
               end
            end
            ST_REQ: begin
               if (!bus.bus_gnt && w_expire)
                  r_err <= 1'b1;
            end
`ifdef VERSA_LOADER_VERIFY_EN
            ST_RD_MIN: begin
               if (bus.bus_gnt)
                  r_rd_min <= bus.per_dout;
            end
            // Compare settles here so err is already valid in the DONE cycle
            ST_RD_MAX: begin
               if (bus.bus_gnt) begin
                  r_rd_max <= bus.per_dout;
                  r_err    <= (r_rd_min != r_min) || (bus.per_dout != r_max);
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.bus_req  = w_bus_req;
   assign bus.per_en   = w_per_en;
   assign bus.per_we   = w_per_we;
   assign bus.per_addr = w_per_addr;
   assign bus.per_din  = w_per_din;
   assign bus.busy     = (r_state != ST_IDLE);
   assign bus.done     = (r_state == ST_DONE);
   assign bus.err      = r_err;
`ifdef VERSA_LOADER_VERIFY_EN
   assign bus.rd_min   = r_rd_min;
   assign bus.rd_max   = r_rd_max;
`else
   assign bus.rd_min   = 16'd0;
   assign bus.rd_max   = 16'd0;
`endif

endmodule

// File: tb/tb_versa_meta_loader.sv
// tb/tb_versa_meta_loader.sv - directed bench for versa_meta_loader with a model metadata responder
module tb_versa_meta_loader;

`ifdef VERSA_LOADER_VERIFY_EN
   localparam bit VERIFY   = 1'b1;
   localparam int DONE_CYC = 6;
`else
   localparam bit VERIFY   = 1'b0;
   localparam int DONE_CYC = 4;
`endif
   localparam int LIM = 400;

   logic mclk = 1'b0;
   logic puc_rst;
   always #5 mclk = ~mclk;

   versa_meta_loader_if bus ();

   versa_meta_loader #(
      .BASE_ADDR   (15'h0140),
      .GNT_TIMEOUT (8'd255)
   ) dut (
      .mclk    (mclk),
      .puc_rst (puc_rst),
      .bus     (bus.master)
   );

   logic [15:0] mem0;
   logic [15:0] mem1;
   logic        force_max_zero;

   always @(posedge mclk) begin
      if (bus.per_en && bus.per_we == 2'b11) begin
         if (bus.per_addr == 14'h00A0) mem0 <= bus.per_din;
         else if (bus.per_addr == 14'h00A1) mem1 <= bus.per_din;
      end
   end

   always_comb begin
      bus.per_dout = 16'h0000;
      if (bus.per_en && bus.per_addr == 14'h00A0) bus.per_dout = mem0;
      else if (bus.per_en && bus.per_addr == 14'h00A1) bus.per_dout = force_max_zero ? 16'h0000 : mem1;
   end

   int n_chk = 0;
   int n_err = 0;
   logic        en_at   [LIM+1];
   logic        req_at  [LIM+1];
   logic [1:0]  we_at   [LIM+1];
   logic [13:0] addr_at [LIM+1];
   logic [15:0] din_at  [LIM+1];
   int en_cnt;
   int req_cnt;
   int en_drop;
   int dc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start in cycle 0, then step cycles 1.. until done; bus_gnt low in cycles [glo, ghi]
   task automatic run(input logic [15:0] mn, input logic [15:0] mx, input int glo, input int ghi);
      int c;
      @(negedge mclk);
      bus.start    = 1'b1;
      bus.load_min = mn;
      bus.load_max = mx;
      bus.bus_gnt  = 1'b1;
      c = 0; dc = -1; en_cnt = 0; req_cnt = 0; en_drop = 0;
      while (c < LIM && dc < 0) begin
         @(negedge mclk);
         c++;
         bus.start   = 1'b0;
         bus.bus_gnt = !(c >= glo && c <= ghi);
         #1;
         en_at[c] = bus.per_en; req_at[c] = bus.bus_req; we_at[c] = bus.per_we;
         addr_at[c] = bus.per_addr; din_at[c] = bus.per_din;
         en_cnt  += int'(bus.per_en);
         req_cnt += int'(bus.bus_req);
         if (c >= glo && c <= ghi) en_drop += int'(bus.per_en);
         if (bus.done) dc = c;
      end
      bus.bus_gnt = 1'b1;
      if (dc < 0) chk("done_seen", 32'd0, 32'd1);
   endtask

   initial begin
      puc_rst = 1'b1;
      bus.start = 1'b0; bus.load_min = 16'h0; bus.load_max = 16'h0; bus.bus_gnt = 1'b1;
      force_max_zero = 1'b0;
      repeat (3) @(negedge mclk);
      #1;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      chk("rst_req", {31'd0, bus.bus_req}, 32'd0);
      chk("rst_en", {31'd0, bus.per_en}, 32'd0);
      chk("rst_rdmax", {16'd0, bus.rd_max}, 32'd0);
      puc_rst = 1'b0;

      // Nominal load with grant tied high
      run(16'hE07A, 16'hF000, 1000, 1000);
      chk("t1_done_cyc", dc, DONE_CYC);
      chk("t1_req_c1", {31'd0, req_at[1]}, 32'd1);
      chk("t1_en_c1", {31'd0, en_at[1]}, 32'd0);
      chk("t1_wrmin", {en_at[2], we_at[2], addr_at[2], din_at[2]}, {1'b1, 2'b11, 14'h00A0, 16'hE07A});
      chk("t1_wrmax", {en_at[3], we_at[3], addr_at[3], din_at[3]}, {1'b1, 2'b11, 14'h00A1, 16'hF000});
      if (VERIFY) begin
         chk("t1_rdmin", {en_at[4], we_at[4], addr_at[4], din_at[4]}, {1'b1, 2'b00, 14'h00A0, 16'h0000});
         chk("t1_rd_min", {16'd0, bus.rd_min}, 32'h0000E07A);
         chk("t1_rd_max", {16'd0, bus.rd_max}, 32'h0000F000);
      end
      chk("t1_err", {31'd0, bus.err}, 32'd0);
      chk("t1_mem", {mem0, mem1}, 32'hE07AF000);
      @(negedge mclk); #1;
      chk("t1_busy_after", {31'd0, bus.busy}, 32'd0);

      // Inverted range is rejected without touching the bus
      run(16'hF000, 16'hE07A, 1000, 1000);
      chk("t2_done_cyc", dc, 1);
      chk("t2_err", {31'd0, bus.err}, 32'd1);
      chk("t2_en_cnt", en_cnt, 0);
      chk("t2_req_cnt", req_cnt, 0);

      // Equal bounds are legal; also clears the held err
      run(16'h1111, 16'h1111, 1000, 1000);
      chk("t3_done_cyc", dc, DONE_CYC);
      chk("t3_err", {31'd0, bus.err}, 32'd0);

      // Grant never arrives
      run(16'h0010, 16'h0020, 1, 1000);
      chk("t4_done_cyc", dc, 256);
      chk("t4_err", {31'd0, bus.err}, 32'd1);
      chk("t4_req_255", {31'd0, req_at[255]}, 32'd1);
      chk("t4_req_256", {31'd0, req_at[256]}, 32'd0);
      chk("t4_en_cnt", en_cnt, 0);

      // Grant dropped during the three WR_MAX cycles
      run(16'h0300, 16'h0400, 3, 5);
      chk("t5_done_cyc", dc, DONE_CYC + 3);
      chk("t5_en_drop", en_drop, 0);
      chk("t5_wrmax", {en_at[6], addr_at[6], din_at[6]}, {1'b1, 14'h00A1, 16'h0400});
      chk("t5_err", {31'd0, bus.err}, 32'd0);
      chk("t5_mem", {mem0, mem1}, 32'h03000400);

      // ER_max readback corrupted by the responder
      force_max_zero = 1'b1;
      run(16'h0100, 16'h0200, 1000, 1000);
      force_max_zero = 1'b0;
      chk("t6_done_cyc", dc, DONE_CYC);
      chk("t6_err", {31'd0, bus.err}, {31'd0, VERIFY});
      chk("t6_rd_max", {16'd0, bus.rd_max}, 32'd0);
      @(negedge mclk); #1;
      chk("t6_err_held", {31'd0, bus.err}, {31'd0, VERIFY});

      // Reset mid-operation (RD_MIN when verifying, else WR_MAX)
      @(negedge mclk);
      bus.start = 1'b1; bus.load_min = 16'hAAAA; bus.load_max = 16'hBBBB;
      @(negedge mclk); bus.start = 1'b0;
      @(negedge mclk);
      @(negedge mclk);
      if (VERIFY) @(negedge mclk);
      #1;
      chk("t7_en_pre", {31'd0, bus.per_en}, 32'd1);
      puc_rst = 1'b1;
      #1;
      chk("t7_en_rst", {31'd0, bus.per_en}, 32'd0);
      chk("t7_req_rst", {31'd0, bus.bus_req}, 32'd0);
      chk("t7_busy_rst", {31'd0, bus.busy}, 32'd0);
      #1;
      puc_rst = 1'b0;
      run(16'h1234, 16'h5678, 1000, 1000);
      chk("t7_done_cyc", dc, DONE_CYC);
      chk("t7_err", {31'd0, bus.err}, 32'd0);
      chk("t7_mem", {mem0, mem1}, 32'h12345678);
      if (VERIFY) chk("t7_rd", {bus.rd_min, bus.rd_max}, 32'h12345678);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
